// File: rtl/iob_native_rr_arbiter.sv
// Round-robin arbiter sharing one IOb Native subordinate between N_MANAGERS managers.
// One transaction in flight; grant is held through the read-data return.
module iob_native_rr_arbiter #(
  parameter int unsigned N_MANAGERS = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                           clk_i,
  input  logic                           arst_n_i,
  input  logic                           cke_i,
  input  logic [N_MANAGERS-1:0]          m_valid_i,
  input  logic [N_MANAGERS*ADDR_W-1:0]   m_addr_i,
  input  logic [N_MANAGERS*DATA_W-1:0]   m_wdata_i,
  input  logic [N_MANAGERS*DATA_W/8-1:0] m_wstrb_i,
  output logic [N_MANAGERS-1:0]          m_ready_o,
  output logic [N_MANAGERS-1:0]          m_rvalid_o,
  output logic [N_MANAGERS*DATA_W-1:0]   m_rdata_o,
  output logic                           s_valid_o,
  output logic [ADDR_W-1:0]              s_addr_o,
  output logic [DATA_W-1:0]              s_wdata_o,
  output logic [DATA_W/8-1:0]            s_wstrb_o,
  input  logic                           s_ready_i,
  input  logic                           s_rvalid_i,
  input  logic [DATA_W-1:0]              s_rdata_i,
  output logic [$clog2(N_MANAGERS)-1:0]  grant_o,
  output logic                           busy_o
);

  localparam int unsigned GW = $clog2(N_MANAGERS);
  localparam int unsigned SW = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StGrant, StWaitRd} state_e;

  state_e        state_q;
  logic [GW-1:0] grant_idx_q;
  logic [GW-1:0] prio_ptr_q;
  logic [GW-1:0] winner;
  logic [GW-1:0] cand;
  logic [GW-1:0] nxt_ptr;
  logic          found;
  int unsigned   idx;

  // First requester at or above prio_ptr, wrapping around.
  always_comb begin
    winner = prio_ptr_q;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int unsigned i = 0; i < N_MANAGERS; i++) begin
      idx  = (32'(prio_ptr_q) + i) % N_MANAGERS;
      cand = GW'(idx);
      if (!found && m_valid_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign nxt_ptr = (grant_idx_q == GW'(N_MANAGERS - 1)) ? '0 : grant_idx_q + 1'b1;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= StIdle;
      grant_idx_q <= '0;
      prio_ptr_q  <= '0;
    end else if (cke_i) begin
      case (state_q)
        StIdle: begin
          if (found) begin
            grant_idx_q <= winner;
            state_q     <= StGrant;
          end
        end
        StGrant: begin
          if (!m_valid_i[grant_idx_q]) begin
            // Manager withdrew before handshake: abandon without rotating priority.
            state_q <= StIdle;
          end else if (s_ready_i) begin
            if (|s_wstrb_o) begin
              state_q    <= StIdle;
              prio_ptr_q <= nxt_ptr;
            end else begin
              state_q <= StWaitRd;
            end
          end
        end
        StWaitRd: begin
          if (s_rvalid_i) begin
            state_q    <= StIdle;
            prio_ptr_q <= nxt_ptr;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    s_valid_o  = 1'b0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    s_wstrb_o  = '0;
    m_ready_o  = '0;
    m_rvalid_o = '0;
    if (state_q == StGrant) begin
      s_valid_o              = m_valid_i[grant_idx_q];
      s_addr_o               = m_addr_i[32'(grant_idx_q)*ADDR_W +: ADDR_W];
      s_wdata_o              = m_wdata_i[32'(grant_idx_q)*DATA_W +: DATA_W];
      s_wstrb_o              = m_wstrb_i[32'(grant_idx_q)*SW +: SW];
      m_ready_o[grant_idx_q] = s_ready_i;
    end else if (state_q == StWaitRd) begin
      m_rvalid_o[grant_idx_q] = s_rvalid_i;
    end
  end

  assign m_rdata_o = {N_MANAGERS{s_rdata_i}};
  assign grant_o   = grant_idx_q;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_iob_native_rr_arbiter.sv
// Directed bench for iob_native_rr_arbiter: handshakes and read returns are checked
// against a scoreboard of expectations queued when the stimulus is driven.
module tb_iob_native_rr_arbiter;

  logic        clk;
  logic        arst_n;
  logic        cke;
  logic [1:0]  m_valid;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_ready;
  logic [1:0]  m_rvalid;
  logic [63:0] m_rdata;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic        s_rvalid;
  logic [31:0] s_rdata;
  logic [0:0]  grant;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [0:0]  grant;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } hs_t;

  typedef struct {
    logic [1:0]  rv;
    logic [31:0] data;
  } rd_t;

  hs_t hs_q[$];
  rd_t rd_q[$];

  iob_native_rr_arbiter #(
    .N_MANAGERS(2),
    .ADDR_W    (32),
    .DATA_W    (32)
  ) dut (
    .clk_i     (clk),
    .arst_n_i  (arst_n),
    .cke_i     (cke),
    .m_valid_i (m_valid),
    .m_addr_i  (m_addr),
    .m_wdata_i (m_wdata),
    .m_wstrb_i (m_wstrb),
    .m_ready_o (m_ready),
    .m_rvalid_o(m_rvalid),
    .m_rdata_o (m_rdata),
    .s_valid_o (s_valid),
    .s_addr_o  (s_addr),
    .s_wdata_o (s_wdata),
    .s_wstrb_o (s_wstrb),
    .s_ready_i (s_ready),
    .s_rvalid_i(s_rvalid),
    .s_rdata_i (s_rdata),
    .grant_o   (grant),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, called once per cycle at the falling edge.
  task automatic mon();
    hs_t h;
    rd_t r;
    if (!arst_n) return;
    if (s_valid && s_ready) begin
      if (hs_q.size() == 0) begin
        chk("hs_unexpected", 64'(s_valid & s_ready), 64'(0));
      end else begin
        h = hs_q.pop_front();
        chk("hs_grant", 64'(grant), 64'(h.grant));
        chk("hs_addr", 64'(s_addr), 64'(h.addr));
        chk("hs_wdata", 64'(s_wdata), 64'(h.wdata));
        chk("hs_wstrb", 64'(s_wstrb), 64'(h.wstrb));
      end
    end
    if (m_rvalid !== 2'b00) begin
      if (rd_q.size() == 0) begin
        chk("rvalid_unexpected", 64'(m_rvalid), 64'(0));
      end else begin
        r = rd_q.pop_front();
        chk("rd_rvalid", 64'(m_rvalid), 64'(r.rv));
        chk("rd_data0", 64'(m_rdata[31:0]), 64'(r.data));
        chk("rd_data1", 64'(m_rdata[63:32]), 64'(r.data));
      end
    end
  endtask

  task automatic smp();
    @(negedge clk);
    mon();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    smp();
    tick();
  endtask

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    m_addr[k*32 +: 32]  = a;
    m_wdata[k*32 +: 32] = d;
    m_wstrb[k*4 +: 4]   = s;
  endtask

  task automatic push_hs(input int k, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    hs_t h;
    h.grant = 1'(k);
    h.addr  = a;
    h.wdata = d;
    h.wstrb = s;
    hs_q.push_back(h);
  endtask

  task automatic push_rd(input logic [1:0] rv, input logic [31:0] d);
    rd_t r;
    r.rv   = rv;
    r.data = d;
    rd_q.push_back(r);
  endtask

  initial begin
    arst_n   = 1'b0;
    cke      = 1'b1;
    m_valid  = 2'b11;
    m_addr   = {32'h14, 32'h10};
    m_wdata  = {32'h2222_2222, 32'h1111_1111};
    m_wstrb  = 8'hFF;
    s_ready  = 1'b0;
    s_rvalid = 1'b0;
    s_rdata  = '0;

    // Reset values with both managers requesting.
    repeat (3) cyc();
    smp();
    chk("rst_s_valid", 64'(s_valid), 64'(0));
    chk("rst_s_addr", 64'(s_addr), 64'(0));
    chk("rst_s_wdata", 64'(s_wdata), 64'(0));
    chk("rst_s_wstrb", 64'(s_wstrb), 64'(0));
    chk("rst_m_ready", 64'(m_ready), 64'(0));
    chk("rst_m_rvalid", 64'(m_rvalid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_m_rdata", m_rdata, 64'(0));
    tick();
    arst_n = 1'b1;
    smp();
    chk("rel_busy", 64'(busy), 64'(0));
    tick();
    smp();
    chk("rel_grant", 64'(grant), 64'(0));
    chk("rel_s_valid", 64'(s_valid), 64'(1));
    chk("rel_s_addr", 64'(s_addr), 64'(32'h10));
    tick();
    m_valid = 2'b00;
    smp();
    chk("drop_s_valid", 64'(s_valid), 64'(0));
    tick();
    smp();
    chk("drop_idle", 64'(busy), 64'(0));
    tick();

    // Single write from manager 1, zero-wait subordinate.
    m_valid = 2'b10;
    set_req(1, 32'h4, 32'hA5A5_0000, 4'hC);
    s_ready = 1'b1;
    push_hs(1, 32'h4, 32'hA5A5_0000, 4'hC);
    smp();
    chk("wr_ready_idle", 64'(m_ready), 64'(0));
    tick();
    smp();
    chk("wr_ready", 64'(m_ready), 64'(2'b10));
    chk("wr_s_addr", 64'(s_addr), 64'(32'h4));
    tick();
    m_valid = 2'b00;
    smp();
    chk("wr_ready_after", 64'(m_ready), 64'(0));
    chk("wr_busy_after", 64'(busy), 64'(0));
    tick();

    // Read from manager 0 with 3 wait states, rvalid 2 cycles after ready.
    m_valid = 2'b01;
    set_req(0, 32'h8, 32'h0, 4'h0);
    s_ready = 1'b0;
    push_hs(0, 32'h8, 32'h0, 4'h0);
    push_rd(2'b01, 32'h1234_5678);
    cyc();
    smp();
    chk("rdw_s_valid", 64'(s_valid), 64'(1));
    chk("rdw_m_ready", 64'(m_ready), 64'(0));
    tick();
    cyc();
    cyc();
    s_ready = 1'b1;
    cyc();
    s_ready = 1'b0;
    m_valid = 2'b00;
    smp();
    chk("rdw_wait_rvalid", 64'(m_rvalid), 64'(0));
    chk("rdw_wait_busy", 64'(busy), 64'(1));
    chk("rdw_wait_s_valid", 64'(s_valid), 64'(0));
    tick();
    s_rvalid = 1'b1;
    s_rdata  = 32'h1234_5678;
    cyc();
    s_rvalid = 1'b0;
    smp();
    chk("rdw_rvalid_after", 64'(m_rvalid), 64'(0));
    chk("rdw_busy_after", 64'(busy), 64'(0));
    tick();

    // Round-robin from reset: 4 back-to-back writes per manager.
    arst_n = 1'b0;
    s_ready = 1'b1;
    for (int k = 0; k < 2; k++) set_req(k, 32'(k*256), 32'hC0DE_0000 | 32'(k*256), 4'(k ? 3 : 15));
    m_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 2; k++) begin
        push_hs(k, 32'(k*256 + j*4), 32'hC0DE_0000 | 32'(k*256 + j), 4'(k ? 3 : 15));
      end
    end
    cyc();
    arst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      smp();
      chk("rr_idle_busy", 64'(busy), 64'(0));
      tick();
      smp();
      chk("rr_s_valid", 64'(s_valid), 64'(1));
      chk("rr_grant", 64'(grant), 64'(t % 2));
      tick();
      if (t / 2 == 3) begin
        m_valid[t % 2] = 1'b0;
      end else begin
        set_req(t % 2, 32'((t % 2)*256 + (t/2 + 1)*4), 32'hC0DE_0000 | 32'((t % 2)*256 + t/2 + 1),
                4'((t % 2) ? 3 : 15));
      end
    end
    chk("rr_drained", 64'(hs_q.size()), 64'(0));

    // Read by manager 0 blocks manager 1 until rvalid returns.
    m_valid = 2'b01;
    set_req(0, 32'h20, 32'h0, 4'h0);
    push_hs(0, 32'h20, 32'h0, 4'h0);
    cyc();
    cyc();
    m_valid = 2'b10;
    set_req(1, 32'h30, 32'h3030_3030, 4'hF);
    smp();
    chk("blk_m_ready0", 64'(m_ready), 64'(0));
    chk("blk_s_valid", 64'(s_valid), 64'(0));
    tick();
    smp();
    chk("blk_m_ready1", 64'(m_ready), 64'(0));
    tick();
    s_rvalid = 1'b1;
    s_rdata  = 32'hCAFE_F00D;
    push_rd(2'b01, 32'hCAFE_F00D);
    smp();
    chk("blk_m_ready2", 64'(m_ready), 64'(0));
    tick();
    s_rvalid = 1'b0;
    push_hs(1, 32'h30, 32'h3030_3030, 4'hF);
    smp();
    chk("blk_idle_s_valid", 64'(s_valid), 64'(0));
    chk("blk_idle_busy", 64'(busy), 64'(0));
    tick();
    smp();
    chk("blk_m1_s_valid", 64'(s_valid), 64'(1));
    chk("blk_m1_grant", 64'(grant), 64'(1));
    chk("blk_m1_ready", 64'(m_ready), 64'(2'b10));
    tick();
    m_valid = 2'b00;
    cyc();

    // Reset during WAIT_RD; a late rvalid must be dropped and priority restored to 0.
    m_valid = 2'b01;
    set_req(0, 32'h50, 32'h5050_5050, 4'hF);
    push_hs(0, 32'h50, 32'h5050_5050, 4'hF);
    cyc();
    cyc();
    m_valid = 2'b10;
    set_req(1, 32'h60, 32'h0, 4'h0);
    push_hs(1, 32'h60, 32'h0, 4'h0);
    cyc();
    cyc();
    m_valid = 2'b00;
    smp();
    chk("mid_busy", 64'(busy), 64'(1));
    chk("mid_grant", 64'(grant), 64'(1));
    tick();
    arst_n = 1'b0;
    smp();
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_grant", 64'(grant), 64'(0));
    tick();
    arst_n = 1'b1;
    s_rvalid = 1'b1;
    s_rdata  = 32'hDEAD_BEEF;
    smp();
    chk("late_rvalid", 64'(m_rvalid), 64'(0));
    chk("late_busy", 64'(busy), 64'(0));
    tick();
    s_rvalid = 1'b0;
    smp();
    chk("late_idle", 64'(busy), 64'(0));
    tick();
    s_ready = 1'b0;
    m_valid = 2'b11;
    set_req(0, 32'h70, 32'h0, 4'hF);
    set_req(1, 32'h74, 32'h0, 4'hF);
    cyc();
    smp();
    chk("prio_after_rst", 64'(grant), 64'(0));
    tick();
    m_valid = 2'b00;
    cyc();
    cyc();

    chk("hs_q_empty", 64'(hs_q.size()), 64'(0));
    chk("rd_q_empty", 64'(rd_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
